load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of the request and memory address buses.
REQ-002 Parameter MEM_RD_LATENCY, default 1, legal range 1-15; cycles mem_read_en is held before mem_read_data is sampled.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge system clock; rst_n input 1, asynchronous active-low reset.
REQ-004 req_valid input 1, request present; req_ready output 1, block accepts the request when both are high on a clk edge.
REQ-005 req_write input 1, 1 = store, 0 = load; req_size input 2, 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-006 req_unsigned input 1, loads zero-extend when high and sign-extend when low; req_addr input ADDR_WIDTH, byte address; req_wdata input 32, store data, LSB-justified.
REQ-007 resp_valid output 1, response present; resp_ready input 1, response consumed when both are high; resp_rdata output 32, load result; resp_err output 1, request rejected.
REQ-008 mem_read_en output 1; mem_write_en output 1; mem_addr output ADDR_WIDTH, word-aligned byte address; mem_write_data output 32; mem_read_data input 32. The memory has word granularity and no byte enables.

Function
REQ-009 FSM states: IDLE, READ, WRITE, RESP; req_ready SHALL be high only in IDLE.
REQ-010 Acceptance SHALL register all req_* fields; mem_addr SHALL equal {addr[ADDR_WIDTH-1:2], 2'b00} from acceptance until the next acceptance.
REQ-011 IDLE -> READ on acceptance of any load, or of a byte or halfword store; IDLE -> WRITE on acceptance of a word store.
REQ-012 In READ, mem_read_en SHALL be high for exactly MEM_RD_LATENCY cycles (4-bit counter); mem_read_data SHALL be sampled on the final READ edge.
REQ-013 READ exit: a load -> RESP; a sub-word store -> WRITE, with the sampled word held as the merge base.
REQ-014 In WRITE, mem_write_en SHALL be high for exactly one cycle, then -> RESP.
REQ-015 Store merge: byte replaces lane addr[1:0] (lane 0 = bits 7:0); halfword replaces lane addr[1] (bits 15:0 or 31:16); word replaces all bits; other lanes are unchanged.
REQ-016 Load extract uses the same lanes; bit 7 or bit 15 SHALL be replicated when req_unsigned = 0, and zeros SHALL be filled when req_unsigned = 1; stores return resp_rdata = 0.
REQ-017 RESP holds resp_valid, resp_rdata and resp_err stable until resp_ready; RESP -> IDLE on handshake; no new request is accepted in the same cycle.
REQ-018 mem_read_en and mem_write_en SHALL never be high together, and SHALL both be low in IDLE and RESP.
REQ-019 Latency with resp_ready held high: word store, resp_valid 2 cycles after acceptance; load, 1+MEM_RD_LATENCY cycles; sub-word store, 2+MEM_RD_LATENCY cycles.
REQ-020 req_size = 11 SHALL go IDLE -> RESP with resp_err = 1 and no memory access.

Reset
REQ-021 On rst_n low (asynchronous), the state SHALL become IDLE and the following SHALL clear to 0: req_ready, resp_valid, resp_rdata, resp_err, mem_read_en, mem_write_en, mem_addr, mem_write_data and the counter.
REQ-022 req_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-023 Reset during READ or WRITE SHALL abort the access; no memory enable is asserted after reset asserts.

Configuration
REQ-024 Macro LSU_MISALIGN_CHECK_EN.
REQ-025 When it is defined, a halfword with addr[0] = 1 or a word with addr[1:0] != 00 SHALL go IDLE -> RESP with resp_err = 1, resp_rdata = 0 and no memory access.
REQ-026 When it is undefined, misaligned low bits SHALL be masked to natural alignment (halfword ignores addr[0], word ignores addr[1:0]), and resp_err SHALL assert only for req_size = 11.

Verification
REQ-027 Word store addr 0x10, wdata 0xDEADBEEF, then word load 0x10 -> mem_write_en one cycle with mem_addr 0x10; load resp_rdata = 0xDEADBEEF; resp_valid exactly 2 and 1+MEM_RD_LATENCY cycles after acceptance.
REQ-028 Memory word 0x11223344, byte store 0xAA to addr 0x12 -> mem_read_en then mem_write_data = 0x11AA3344; never both enables high.
REQ-029 Word 0x80FF7F01: lb 0x01 -> 0x0000007F; lb 0x02 -> 0xFFFFFFFF; lbu 0x03 -> 0x00000080; lh 0x02 -> 0xFFFF80FF; lhu 0x02 -> 0x000080FF.
REQ-030 resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready low, no memory enable; the transfer completes on the cycle resp_ready rises.
REQ-031 Halfword load at 0x13 -> with LSU_MISALIGN_CHECK_EN, resp_err = 1 and no mem_read_en; without it, the data comes from lane 1 (bits 31:16) with resp_err = 0.
REQ-032 rst_n asserted mid-READ with MEM_RD_LATENCY = 3 -> all outputs are 0 immediately; req_ready = 1 one edge after release; the next load completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word load and store requests into
// accesses on a word-granular memory without byte enables. Sub-word stores
// are done as read-modify-write. Loads are lane-extracted and sign- or
// zero-extended.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When defined, misaligned
// halfword/word requests are rejected with resp_err. When undefined, the low
// address bits are masked to natural alignment.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  // Counter preload: the read strobe stays up for MEM_RD_LATENCY cycles.
  localparam logic [3:0] LAT_M1  = 4'(MEM_RD_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_out_q, wdata_out_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              lo_q, lo_d;
  logic [31:0]             st_data_q, st_data_d;
  logic                    misalign;

  // Replace the addressed lane(s) of the base word with the store data.
  function automatic logic [31:0] merge_store(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [31:0] w;
    w = base;
    case (size)
      SZ_BYTE: w[{lo, 3'b000} +: 8] = data[7:0];
      SZ_HALF: begin
        if (lo[1]) w[31:16] = data[15:0];
        else       w[15:0]  = data[15:0];
      end
      default: w = data;
    endcase
    return w;
  endfunction

  // Pull the addressed lane out of the read word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic        uns);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] r_s;
    logic [31:0]        r;
    b_s = word[{lo, 3'b000} +: 8];
    h_s = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: begin
        r_s = b_s;
        r   = uns ? {24'd0, b_s} : r_s;
      end
      SZ_HALF: begin
        r_s = h_s;
        r   = uns ? {16'd0, h_s} : r_s;
      end
      SZ_WORD: r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Next-state and next-output computation for the request/response FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    wdata_out_d  = wdata_out_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lo_d         = lo_q;
    st_data_d    = st_data_q;
    case (state_q)
      S_IDLE: begin
        // Ready comes up on the first edge after reset and stays up in IDLE.
        req_ready_d = 1'b1;
        if (req_ready_q && req_valid) begin
          req_ready_d = 1'b0;
          addr_d      = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          write_d     = req_write;
          size_d      = req_size;
          uns_d       = req_unsigned;
          lo_d        = req_addr[1:0];
          st_data_d   = req_wdata;
          if ((req_size == SZ_RSVD) || misalign) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d     = S_WRITE;
            wr_en_d     = 1'b1;
            wdata_out_d = req_wdata;
          end else begin
            state_d = S_READ;
            rd_en_d = 1'b1;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 4'd0) begin
          rd_en_d = 1'b0;
          if (write_q) begin
            // Sub-word store: the read word becomes the merge base.
            state_d     = S_WRITE;
            wr_en_d     = 1'b1;
            wdata_out_d = merge_store(mem_read_data, st_data_q, size_q, lo_q);
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = extract_load(mem_read_data, size_q, lo_q, uns_q);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WRITE: begin
        wr_en_d      = 1'b0;
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_out_q  <= 32'd0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lo_q         <= 2'b00;
      st_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_out_q  <= wdata_out_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lo_q         <= lo_d;
      st_data_q    <= st_data_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mem_read_en    = rd_en_q;
  assign mem_write_en   = wr_en_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_out_q;

endmodule
